display_scan_mux: RTL and testbench

Upstream feeder for the shared seven-segment decoder in the alarm clock display path. Takes four BCD digits (HH:MM) from the time/alarm select logic and time-multiplexes them onto one 4-bit digit code. Drives one-hot active-low digit enables, so a single decoder instance serves all four digits. Also handles:
- leading-zero blanking
- field blinking for set mode
- anti-ghosting guard interval
- frame-coherent input latching

---
 rtl/display_pkg.sv | 19 +
 rtl/display_scan_mux_scan_timer.sv | 83 ++++++++
 rtl/display_scan_mux.sv | 123 ++++++++++++
 tb/tb_display_scan_mux.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Display-path codes and types, shared with the seven-segment decoder.
package display_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [1:0] digit_idx_t;

  localparam bcd_t CODE_BLANK = 4'hA;
  localparam bcd_t CODE_ERR   = 4'hB;
  localparam int   NUM_DIGITS = 4;

  // Error beats every kind of blanking; a valid digit passes through untouched.
  function automatic bcd_t resolve_code(input bcd_t digit, input logic blink_blank,
                                        input logic lz_blank);
    if (digit > 4'd9) return CODE_ERR;
    if (blink_blank || lz_blank) return CODE_BLANK;
    return digit;
  endfunction

endpackage

// File: rtl/display_scan_mux_scan_timer.sv
// Scan timebase: slot counter, digit index, frame boundary and blink phase.
// Exposes next-state values so the top can register outputs aligned with the counter.
module scan_timer
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = 1024,
  parameter int BLINK_FRAMES = 64,
  parameter int SW           = $clog2(SCAN_DIV)
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [SW-1:0] slot_next,
  output logic [1:0]    idx_next,
  output logic          frame_tick,
  output logic          blink_on_next,
  output logic          frame_start
);

  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SW-1:0] slot_q, slot_d;
  digit_idx_t    idx_q, idx_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          blink_on_q, blink_on_d;
  logic          primed_q, primed_d;
  logic          frame_d;
  logic          frame_start_q;

  always_comb begin
    slot_d     = slot_q;
    idx_d      = idx_q;
    frm_d      = frm_q;
    blink_on_d = blink_on_q;
    primed_d   = primed_q;
    frame_d    = 1'b0;
    if (slot_q == SW'(SCAN_DIV - 1)) begin
      slot_d = '0;
      // After reset the first slot wrap starts a real frame instead of stepping the index.
      if (primed_q) begin
        primed_d = 1'b0;
        frame_d  = 1'b1;
      end else begin
        idx_d   = idx_q + 2'd1;
        frame_d = (idx_q == 2'd3);
      end
    end else begin
      slot_d = slot_q + SW'(1);
    end
    if (frame_d) begin
      if (frm_q == FW'(BLINK_FRAMES - 1)) begin
        frm_d      = '0;
        blink_on_d = ~blink_on_q;
      end else begin
        frm_d = frm_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q        <= '0;
      idx_q         <= '0;
      frm_q         <= '0;
      blink_on_q    <= 1'b1;
      primed_q      <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      idx_q         <= idx_d;
      frm_q         <= frm_d;
      blink_on_q    <= blink_on_d;
      primed_q      <= primed_d;
      frame_start_q <= frame_d;
    end
  end

  assign slot_next     = slot_d;
  assign idx_next      = idx_d;
  assign frame_tick    = frame_d;
  assign blink_on_next = blink_on_d;
  assign frame_start   = frame_start_q;

endmodule

// File: rtl/display_scan_mux.sv
// Four-digit BCD scan multiplexer feeding a shared seven-segment decoder.
// Optional DISPLAY_DIM_EN adds a frame-latched brightness[2:0] duty control.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = 1024,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] hr_tens,
  input  logic [3:0] hr_ones,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] blink_mask,
  input  logic       colon_in,
`ifdef DISPLAY_DIM_EN
  input  logic [2:0] brightness,
`endif
  output logic [3:0] digit_code,
  output logic [3:0] digit_en_n,
  output logic       colon_out,
  output logic       frame_start
);

  localparam int            SW      = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] GUARD_W = SW'(GUARD);

  logic [SW-1:0] slot_next;
  logic [1:0]    idx_next;
  logic          frame_tick;
  logic          blink_on_next;

  scan_timer #(
    .SCAN_DIV    (SCAN_DIV),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .slot_next    (slot_next),
    .idx_next     (idx_next),
    .frame_tick   (frame_tick),
    .blink_on_next(blink_on_next),
    .frame_start  (frame_start)
  );

  logic [15:0] lat_digits_q, lat_digits_d;
  logic [3:0]  lat_mask_q, lat_mask_d;
  logic        colon_q, colon_d;
  bcd_t        digit_code_q, digit_code_d;
  logic [3:0]  digit_en_n_q, digit_en_n_d;
  bcd_t        lat_digit [NUM_DIGITS];
`ifdef DISPLAY_DIM_EN
  logic [2:0]    lat_bright_q, lat_bright_d;
  logic [SW-1:0] post_guard;
`endif

  // Shadow registers only move on the frame boundary, keeping each frame coherent.
  always_comb begin
    lat_digits_d = lat_digits_q;
    lat_mask_d   = lat_mask_q;
    colon_d      = colon_q;
`ifdef DISPLAY_DIM_EN
    lat_bright_d = lat_bright_q;
`endif
    if (frame_tick) begin
      lat_digits_d = {hr_tens, hr_ones, min_tens, min_ones};
      lat_mask_d   = blink_mask;
      colon_d      = colon_in & ((blink_mask == 4'b0000) | blink_on_next);
`ifdef DISPLAY_DIM_EN
      lat_bright_d = brightness;
`endif
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign lat_digit[gi] = lat_digits_d[4*gi +: 4];
  end

  always_comb begin
    digit_code_d = resolve_code(lat_digit[idx_next],
                                ~blink_on_next & lat_mask_d[idx_next],
                                (idx_next == 2'd3) && (lat_digit[3] == 4'd0));
    digit_en_n_d = 4'b1111;
`ifdef DISPLAY_DIM_EN
    post_guard = slot_next - GUARD_W;
`endif
    if (slot_next >= GUARD_W) begin
      digit_en_n_d = ~(4'b0001 << idx_next);
`ifdef DISPLAY_DIM_EN
      if (3'(post_guard) > lat_bright_d) digit_en_n_d = 4'b1111;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_digits_q <= '0;
      lat_mask_q   <= '0;
      colon_q      <= 1'b0;
      digit_code_q <= CODE_BLANK;
      digit_en_n_q <= 4'b1111;
`ifdef DISPLAY_DIM_EN
      lat_bright_q <= 3'd7;
`endif
    end else begin
      lat_digits_q <= lat_digits_d;
      lat_mask_q   <= lat_mask_d;
      colon_q      <= colon_d;
      digit_code_q <= digit_code_d;
      digit_en_n_q <= digit_en_n_d;
`ifdef DISPLAY_DIM_EN
      lat_bright_q <= lat_bright_d;
`endif
    end
  end

  assign digit_code = digit_code_q;
  assign digit_en_n = digit_en_n_q;
  assign colon_out  = colon_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Self-checking bench for display_scan_mux: vector table, corner sequences, random run.
module tb_display_scan_mux;
  import display_pkg::*;

  localparam int S  = 8;
  localparam int G  = 2;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] hr_tens = '0, hr_ones = '0, min_tens = '0, min_ones = '0, blink_mask = '0;
  logic       colon_in = 1'b0;
  logic [3:0] digit_code, digit_en_n;
  logic       colon_out, frame_start;
`ifdef DISPLAY_DIM_EN
  logic [2:0] brightness = 3'd7;
`endif

  always #5 clk = ~clk;

  display_scan_mux #(.SCAN_DIV(S), .GUARD(G), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset_n(reset_n),
    .hr_tens(hr_tens), .hr_ones(hr_ones), .min_tens(min_tens), .min_ones(min_ones),
    .blink_mask(blink_mask), .colon_in(colon_in),
`ifdef DISPLAY_DIM_EN
    .brightness(brightness),
`endif
    .digit_code(digit_code), .digit_en_n(digit_en_n),
    .colon_out(colon_out), .frame_start(frame_start)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position derived from edges since reset release.
  int         t, k;
  bcd_t       m_lat [4];
  logic [3:0] m_mask;
  logic       m_colon, m_phase;
  logic [2:0] m_bright;
  logic [3:0] e_code, e_en;
  logic       e_colon, e_fs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    t = 0; k = 0;
    for (int i = 0; i < 4; i++) m_lat[i] = 4'd0;
    m_mask = 4'd0; m_colon = 1'b0; m_bright = 3'd7; m_phase = 1'b1;
  endtask

  task automatic model_edge();
    int slot, digit;
    bcd_t d;
    if (!reset_n) begin
      model_reset();
      return;
    end
    t++;
    e_fs = (t >= S) && (((t - S) % (4 * S)) == 0);
    if (e_fs) begin
      k++;
      m_lat[0] = min_ones; m_lat[1] = min_tens; m_lat[2] = hr_ones; m_lat[3] = hr_tens;
      m_mask = blink_mask; m_colon = colon_in;
`ifdef DISPLAY_DIM_EN
      m_bright = brightness;
`endif
    end
    slot    = (t < S) ? t : (t - S) % S;
    digit   = (t < S) ? 0 : ((t - S) / S) % 4;
    m_phase = ((k / BF) % 2) == 0;
    d = m_lat[digit];
    if (d > 4'd9) e_code = CODE_ERR;
    else if (!m_phase && m_mask[digit]) e_code = CODE_BLANK;
    else if (digit == 3 && d == 4'd0) e_code = CODE_BLANK;
    else e_code = d;
    e_en = (slot < G) ? 4'hF : ~(4'b0001 << digit);
`ifdef DISPLAY_DIM_EN
    if (slot >= G && ((slot - G) % 8) > int'(m_bright)) e_en = 4'hF;
`endif
    e_colon = m_colon && (m_mask == 4'd0 || m_phase);
  endtask

  task automatic model_check();
    if (!reset_n) return;
    check("cyc_code", 32'(digit_code), 32'(e_code));
    check("cyc_en_n", 32'(digit_en_n), 32'(e_en));
    check("cyc_colon", 32'(colon_out), 32'(e_colon));
    check("cyc_frame_start", 32'(frame_start), 32'(e_fs));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic wait_fs(input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (frame_start !== 1'b1 && n < 100);
    if (frame_start !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: frame_start not seen within %0d cycles", name, n);
    end
  endtask

  task automatic set_digits(input logic [3:0] ht, input logic [3:0] ho,
                            input logic [3:0] mt, input logic [3:0] mo);
    hr_tens = ht; hr_ones = ho; min_tens = mt; min_ones = mo;
  endtask

  typedef struct packed {
    logic [3:0]  ht, ho, mt, mo, mask;
    logic        colon;
    logic [15:0] codes;  // {slot3, slot2, slot1, slot0}
    logic        exp_colon;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int on_cnt, off_cnt, n;
    vecs[0] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 1'b1, 16'h1234, 1'b1};
    vecs[1] = '{4'h0, 4'h7, 4'h5, 4'h9, 4'h0, 1'b0, 16'hA759, 1'b0};
    vecs[2] = '{4'h2, 4'h3, 4'h5, 4'hC, 4'h1, 1'b0, 16'h235B, 1'b0};
    vecs[3] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 16'hA000, 1'b1};
    vecs[4] = '{4'h1, 4'hF, 4'h0, 4'h8, 4'h0, 1'b0, 16'h1B08, 1'b0};
    vecs[5] = '{4'h9, 4'h9, 4'h5, 4'h9, 4'h0, 1'b1, 16'h9959, 1'b1};
    vecs[6] = '{4'hE, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 16'hB001, 1'b0};
    model_reset();

    #23;
    check("reset_code", 32'(digit_code), 32'(CODE_BLANK));
    check("reset_en_n", 32'(digit_en_n), 32'hF);
    check("reset_colon", 32'(colon_out), 32'h0);
    check("reset_frame_start", 32'(frame_start), 32'h0);
    reset_n = 1'b1;

    // Table vectors: each is captured at a frame boundary and checked per slot.
    for (int v = 0; v < 7; v++) begin
      set_digits(vecs[v].ht, vecs[v].ho, vecs[v].mt, vecs[v].mo);
      blink_mask = vecs[v].mask;
      colon_in   = vecs[v].colon;
      wait_fs("vec");
      for (int d = 0; d < 4; d++) begin
        repeat (G) step();
        check("vec_code", 32'(digit_code), 32'(vecs[v].codes[4*d +: 4]));
        check("vec_en_n", 32'(digit_en_n), 32'(~(4'b0001 << d) & 4'hF));
        if (d == 0) check("vec_colon", 32'(colon_out), 32'(vecs[v].exp_colon));
        repeat (S - G) step();
      end
      $display("vec %0d: in %h%h:%h%h mask %b colon %b -> codes %h colon %b",
               v, vecs[v].ht, vecs[v].ho, vecs[v].mt, vecs[v].mo, vecs[v].mask,
               vecs[v].colon, vecs[v].codes, vecs[v].exp_colon);
    end

    // Blink: minutes and colon alternate every BF frames, hours stay steady.
    set_digits(4'h1, 4'h2, 4'h3, 4'h4);
    blink_mask = 4'b0011; colon_in = 1'b1;
    wait_fs("blink");
    on_cnt = 0; off_cnt = 0;
    for (int f = 0; f < 4; f++) begin
      repeat (G) step();
      check("blink_min_ones", 32'(digit_code), m_phase ? 32'h4 : 32'(CODE_BLANK));
      check("blink_colon", 32'(colon_out), 32'(m_phase));
      if (colon_out === 1'b1) on_cnt++; else off_cnt++;
      repeat (3 * S) step();
      check("blink_hr_tens", 32'(digit_code), 32'h1);
      repeat (S - G) step();
    end
    check("blink_on_frames", 32'(on_cnt), 32'd2);
    check("blink_off_frames", 32'(off_cnt), 32'd2);
    $display("blink: %0d frames on, %0d off", on_cnt, off_cnt);

    // Error overrides blink during an off phase.
    min_ones = 4'hC; blink_mask = 4'b1111;
    do wait_fs("err_blink"); while (m_phase && t < 2000);
    repeat (G) step();
    check("err_over_blink", 32'(digit_code), 32'(CODE_ERR));
    $display("error-over-blink: slot0 code %h", digit_code);

    // Mid-frame change is held off until the next frame boundary.
    blink_mask = 4'b0000; min_ones = 4'h5;
    wait_fs("midframe");
    repeat (3) step();
    min_ones = 4'h6;
    repeat (2) step();
    check("midframe_hold", 32'(digit_code), 32'h5);
    wait_fs("midframe_next");
    repeat (G) step();
    check("midframe_update", 32'(digit_code), 32'h6);
    $display("midframe: held 5, then showed %h", digit_code);

    // Asynchronous reset in the middle of slot 2.
    wait_fs("reset_mid");
    repeat (2 * S + 3) step();
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_code", 32'(digit_code), 32'(CODE_BLANK));
    check("rst_async_en_n", 32'(digit_en_n), 32'hF);
    check("rst_async_colon", 32'(colon_out), 32'h0);
    check("rst_async_fs", 32'(frame_start), 32'h0);
    step();
    step();
    #2 reset_n = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (frame_start !== 1'b1 && n < 3 * S);
    check("rst_first_fs_delay", 32'(n), 32'(S));
    $display("reset: first frame_start %0d cycles after release", n);

    // Randomised run against the model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        set_digits(4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
                   4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)));
        blink_mask = 4'($urandom_range(0, 15));
        colon_in   = 1'($urandom_range(0, 1));
`ifdef DISPLAY_DIM_EN
        brightness = 3'($urandom_range(0, 7));
`endif
      end
      step();
    end
    $display("random: 1500 cycles checked against model");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
